// File: rtl/sequence_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sequence_controller                                    |
// | Description : Plays a stored 64-bit sequence table from a sync BRAM  |
// |               into the slice decoder, holding each entry step_len    |
// |               clocks and repeating the table rep_count times.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sequence_controller #(
  parameter int ADDR_WIDTH = 12,
  parameter int STEP_WIDTH = 32,
  parameter int REP_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [STEP_WIDTH-1:0] step_len,
  input  logic [ADDR_WIDTH:0]   seq_len,
  input  logic [REP_WIDTH-1:0]  rep_count,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  input  logic [63:0]           bram_rdata,
  output logic [63:0]           seq_data,
  output logic                  step_strobe,
  output logic [ADDR_WIDTH-1:0] step_index,
  output logic [REP_WIDTH-1:0]  pass_count,
  output logic                  active,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] c_one_addr = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   c_one_len  = (ADDR_WIDTH+1)'(1);
  localparam logic [STEP_WIDTH-1:0] c_one_step = STEP_WIDTH'(1);
  localparam logic [STEP_WIDTH-1:0] c_two_step = STEP_WIDTH'(2);
  localparam logic [REP_WIDTH-1:0]  c_one_rep  = REP_WIDTH'(1);

  state_t                  r_state;
  state_t                  state_next;

  // Configuration captured at the accepted start
  logic [STEP_WIDTH-1:0]   r_step_len_eff;
  logic [ADDR_WIDTH:0]     r_seq_len;
  logic [REP_WIDTH-1:0]    r_rep_count;

  logic [1:0]              r_prime_cnt;
  logic [STEP_WIDTH-1:0]   r_step_cnt;
  logic                    r_rvalid;
  logic [63:0]             r_next_word;

  logic [ADDR_WIDTH-1:0]   r_bram_addr;
  logic                    r_bram_en;
  logic [63:0]             r_seq_data;
  logic                    r_step_strobe;
  logic [ADDR_WIDTH-1:0]   r_step_index;
  logic [REP_WIDTH-1:0]    r_pass_count;
  logic                    r_done;

  logic                    w_start_ok;
  logic                    w_last;
  logic [REP_WIDTH-1:0]    w_pass_inc;
  logic [ADDR_WIDTH-1:0]   w_succ_addr;
  logic [63:0]             w_next_word;
  logic                    w_do_abort;
  logic                    w_do_restart;
  logic                    w_do_first;
  logic                    w_do_step;
  logic                    w_do_finish;

  assign w_start_ok  = start && !stop && (seq_len != '0);
  assign w_last      = ({1'b0, r_step_index} == (r_seq_len - c_one_len));
  assign w_pass_inc  = r_pass_count + c_one_rep;
  // bram_addr always holds the prefetched (next) index; its successor wraps at seq_len
  assign w_succ_addr = (({1'b0, r_bram_addr} + c_one_len) == r_seq_len) ? '0
                                                                         : (r_bram_addr + c_one_addr);
  // With a 2-cycle hold the prefetched word arrives on the transition edge itself
  assign w_next_word = r_rvalid ? bram_rdata : r_next_word;

  assign bram_addr   = r_bram_addr;
  assign bram_en     = r_bram_en;
  assign seq_data    = r_seq_data;
  assign step_strobe = r_step_strobe;
  assign step_index  = r_step_index;
  assign pass_count  = r_pass_count;
  assign done        = r_done;
  assign active      = (r_state != S_IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= state_next;
    end
  end

  // Next-state and event decode: stop beats start, start beats normal progress
  always_comb begin
    state_next   = r_state;
    w_do_abort   = 1'b0;
    w_do_restart = 1'b0;
    w_do_first   = 1'b0;
    w_do_step    = 1'b0;
    w_do_finish  = 1'b0;
    if (stop && (r_state != S_IDLE)) begin
      w_do_abort = 1'b1;
      state_next = S_IDLE;
    end else if (w_start_ok) begin
      w_do_restart = 1'b1;
      state_next   = S_PRIME;
    end else begin
      case (r_state)
        S_PRIME: begin
          if (r_prime_cnt == 2'd2) begin
            w_do_first = 1'b1;
            state_next = S_RUN;
          end
        end
        S_RUN: begin
          if (r_step_cnt == r_step_len_eff) begin
            if (w_last && (r_rep_count != '0) && (w_pass_inc == r_rep_count)) begin
              w_do_finish = 1'b1;
              state_next  = S_IDLE;
            end else begin
              w_do_step = 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Datapath: config latch, BRAM read pipeline, output word and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step_len_eff <= '0;
      r_seq_len      <= '0;
      r_rep_count    <= '0;
      r_prime_cnt    <= '0;
      r_step_cnt     <= '0;
      r_rvalid       <= 1'b0;
      r_next_word    <= '0;
      r_bram_addr    <= '0;
      r_bram_en      <= 1'b0;
      r_seq_data     <= '0;
      r_step_strobe  <= 1'b0;
      r_step_index   <= '0;
      r_pass_count   <= '0;
      r_done         <= 1'b0;
    end else begin
      r_step_strobe <= 1'b0;
      r_done        <= 1'b0;
      r_bram_en     <= 1'b0;
      r_rvalid      <= r_bram_en;
      if (r_rvalid) begin
        r_next_word <= bram_rdata;
      end
      if (w_do_abort) begin
        r_seq_data   <= '0;
        r_done       <= 1'b1;
        r_step_index <= '0;
      end else if (w_do_restart) begin
        r_step_len_eff <= (step_len < c_two_step) ? c_two_step : step_len;
        r_seq_len      <= seq_len;
        r_rep_count    <= rep_count;
        r_pass_count   <= '0;
        r_step_cnt     <= '0;
        r_prime_cnt    <= '0;
      end else if (w_do_first) begin
        r_seq_data    <= bram_rdata;
        r_step_strobe <= 1'b1;
        r_step_index  <= '0;
        r_bram_en     <= 1'b1;
        r_bram_addr   <= w_succ_addr;
        r_step_cnt    <= c_one_step;
      end else if (w_do_finish) begin
        r_seq_data   <= '0;
        r_done       <= 1'b1;
        r_step_index <= '0;
        r_pass_count <= w_pass_inc;
      end else if (w_do_step) begin
        r_seq_data    <= w_next_word;
        r_step_strobe <= 1'b1;
        r_step_index  <= r_bram_addr;
        r_bram_en     <= 1'b1;
        r_bram_addr   <= w_succ_addr;
        r_step_cnt    <= c_one_step;
        if (w_last) begin
          r_pass_count <= w_pass_inc;
        end
      end else begin
        if (r_state == S_PRIME) begin
          r_prime_cnt <= r_prime_cnt + 2'd1;
          if (r_prime_cnt == 2'd0) begin
            r_bram_en   <= 1'b1;
            r_bram_addr <= '0;
          end
        end
        if (r_state == S_RUN) begin
          r_step_cnt <= r_step_cnt + c_one_step;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sequence_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_sequence_controller                                 |
// | Description : Directed self-checking bench for sequence_controller   |
// |               with a 1-cycle-latency BRAM model.                     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_sequence_controller;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [31:0] step_len;
  logic [12:0] seq_len;
  logic [15:0] rep_count;
  logic [11:0] bram_addr;
  logic        bram_en;
  logic [63:0] bram_rdata;
  logic [63:0] seq_data;
  logic        step_strobe;
  logic [11:0] step_index;
  logic [15:0] pass_count;
  logic        active;
  logic        done;

  logic [63:0] mem [0:4095];
  int          n_total;
  int          n_bad;

  sequence_controller #(
    .ADDR_WIDTH(12),
    .STEP_WIDTH(32),
    .REP_WIDTH (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .step_len   (step_len),
    .seq_len    (seq_len),
    .rep_count  (rep_count),
    .bram_addr  (bram_addr),
    .bram_en    (bram_en),
    .bram_rdata (bram_rdata),
    .seq_data   (seq_data),
    .step_strobe(step_strobe),
    .step_index (step_index),
    .pass_count (pass_count),
    .active     (active),
    .done       (done)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous BRAM model, one cycle read latency
  always @(posedge clk) begin
    if (bram_en) bram_rdata <= mem[bram_addr];
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge with the given config; returns 1 time unit after that edge
  task automatic do_start(input int sl, input int ln, input int rc);
    step_len  = 32'(sl);
    seq_len   = 13'(ln);
    rep_count = 16'(rc);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // Called on the edge where entry 0 lands; checks nsteps entries each held len_eff cycles
  task automatic follow(input int nsteps, input int len_eff, input int slen);
    for (int s = 0; s < nsteps; s++) begin
      for (int c = 0; c < len_eff; c++) begin
        chk("word", seq_data, mem[s % slen]);
        chk("strobe", 64'(step_strobe), (c == 0) ? 64'd1 : 64'd0);
        if (c == 0) begin
          chk("index", 64'(step_index), 64'(s % slen));
          chk("pass", 64'(pass_count), 64'(s / slen));
          chk("done_low", 64'(done), 64'd0);
        end
        tick();
      end
    end
  endtask

  task automatic check_finished(input int passes);
    chk("end_word", seq_data, 64'd0);
    chk("end_done", 64'(done), 64'd1);
    chk("end_active", 64'(active), 64'd0);
    chk("end_pass", 64'(pass_count), 64'(passes));
    chk("end_index", 64'(step_index), 64'd0);
    tick();
    chk("done_once", 64'(done), 64'd0);
    chk("idle_strobe", 64'(step_strobe), 64'd0);
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    start     = 1'b0;
    stop      = 1'b0;
    step_len  = '0;
    seq_len   = '0;
    rep_count = '0;
    for (int i = 0; i < 4096; i++) begin
      mem[i] = {16'hBEEF, 16'(i), 32'(i) * 32'h0101_0101 + 32'h1357_9BDF};
    end

    // Reset state
    rst = 1'b1;
    #1;
    chk("rst_word", seq_data, 64'd0);
    chk("rst_active", 64'(active), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_en", 64'(bram_en), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass_count), 64'd0);

    // Ignored events in IDLE: start with seq_len=0, stop alone
    do_start(5, 0, 1);
    chk("len0_active", 64'(active), 64'd0);
    tick();
    chk("len0_en", 64'(bram_en), 64'd0);
    pulse_stop();
    chk("idle_stop_done", 64'(done), 64'd0);

    // Basic run: 4 entries, hold 5, 2 passes; config changes after start are ignored
    do_start(5, 4, 2);
    step_len  = 32'd9;
    seq_len   = 13'd7;
    rep_count = 16'd5;
    chk("prime_active", 64'(active), 64'd1);
    chk("prime_en0", 64'(bram_en), 64'd0);
    tick();
    chk("prime_en", 64'(bram_en), 64'd1);
    chk("prime_addr", 64'(bram_addr), 64'd0);
    tick();
    chk("prime_word", seq_data, 64'd0);
    chk("prime_en_off", 64'(bram_en), 64'd0);
    tick();
    follow(8, 5, 4);
    check_finished(2);

    // step_len 0 and 1 both behave as 2: 16 entries, 3 passes
    for (int k = 0; k < 2; k++) begin
      do_start(k, 16, 3);
      tick();
      tick();
      tick();
      follow(48, 2, 16);
      check_finished(3);
    end

    // Endless run, stopped mid-way
    do_start(3, 3, 0);
    tick();
    tick();
    tick();
    follow(50, 3, 3);
    chk("inf_index", 64'(step_index), 64'd2);
    pulse_stop();
    chk("stop_word", seq_data, 64'd0);
    chk("stop_done", 64'(done), 64'd1);
    chk("stop_active", 64'(active), 64'd0);
    chk("stop_en", 64'(bram_en), 64'd0);
    tick();
    chk("stop_done_once", 64'(done), 64'd0);

    // start and stop together while running: stop wins, no PRIME read
    do_start(4, 5, 0);
    tick();
    tick();
    tick();
    follow(2, 4, 5);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("ss_word", seq_data, 64'd0);
    chk("ss_done", 64'(done), 64'd1);
    chk("ss_active", 64'(active), 64'd0);
    tick();
    chk("ss_no_read", 64'(bram_en), 64'd0);
    chk("ss_idle", 64'(active), 64'd0);
    tick();
    chk("ss_no_read2", 64'(bram_en), 64'd0);

    // Restart while running at index 2 (second pass)
    do_start(5, 3, 0);
    tick();
    tick();
    tick();
    follow(5, 5, 3);
    tick();
    chk("pre_rs_index", 64'(step_index), 64'd2);
    chk("pre_rs_pass", 64'(pass_count), 64'd1);
    do_start(5, 3, 0);
    chk("rs_pass", 64'(pass_count), 64'd0);
    chk("rs_done", 64'(done), 64'd0);
    chk("rs_keep", seq_data, mem[2]);
    tick();
    chk("rs_en", 64'(bram_en), 64'd1);
    chk("rs_addr", 64'(bram_addr), 64'd0);
    tick();
    chk("rs_keep2", seq_data, mem[2]);
    tick();
    follow(4, 5, 3);

    // Asynchronous reset mid-run
    chk("pre_rst_word", seq_data, mem[1]);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_word", seq_data, 64'd0);
    chk("arst_active", 64'(active), 64'd0);
    chk("arst_index", 64'(step_index), 64'd0);
    chk("arst_pass", 64'(pass_count), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("post_rst_word", seq_data, 64'd0);
    chk("post_rst_active", 64'(active), 64'd0);
    chk("post_rst_en", 64'(bram_en), 64'd0);
    chk("post_rst_strobe", 64'(step_strobe), 64'd0);
    chk("post_rst_done", 64'(done), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
